spi_target_shifter: RTL and testbench

//  SPI target (responder) datapath: the receiving end of the divided serial clock produced by our

---
 rtl/spi_target_shifter.sv | 143 ++++++++++++++
 tb/tb_spi_target_shifter.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/spi_target_shifter.sv
// SPI target datapath: oversamples sclk/cs_n/mosi on clk_in, deserialises mosi
// into WIDTH-bit words and serialises tx words onto miso, all four CPOL/CPHA modes.
module spi_target_shifter #(
  parameter int unsigned WIDTH     = 8,
  parameter logic [15:0] IDLE_FILL = 16'h00FF
) (
  input  logic             clk_in,
  input  logic             async_rst,
  input  logic             cpol,
  input  logic             cpha,
  input  logic             sclk,
  input  logic             cs_n,
  input  logic             mosi,
  output logic             miso,
  output logic             miso_oe,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic             tx_underrun,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  output logic             rx_abort
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  state_t           state;
  logic             sclk_s1, sclk_s2, sclk_q;
  logic             cs_s1, cs_s2;
  logic             mosi_s1, mosi_s2;
  logic [WIDTH-1:0] tx_sh;
  logic [WIDTH-1:0] rx_sh;
  logic [CNT_W-1:0] bit_cnt;

  logic             sclk_chg;
  logic             lead_edge;
  logic             trail_edge;
  logic             sample_edge;
  logic             shift_edge;
  logic             word_done;
  logic [WIDTH-1:0] load_word;

  // Two-flop synchronisers plus the delayed sclk copy used for edge detection
  always_ff @(posedge clk_in or posedge async_rst) begin
    if (async_rst) begin
      sclk_s1 <= 1'b0;
      sclk_s2 <= 1'b0;
      sclk_q  <= 1'b0;
      cs_s1   <= 1'b1;
      cs_s2   <= 1'b1;
      mosi_s1 <= 1'b0;
      mosi_s2 <= 1'b0;
    end else begin
      sclk_s1 <= sclk;
      sclk_s2 <= sclk_s1;
      sclk_q  <= sclk_s2;
      cs_s1   <= cs_n;
      cs_s2   <= cs_s1;
      mosi_s1 <= mosi;
      mosi_s2 <= mosi_s1;
    end
  end

  assign sclk_chg    = sclk_s2 != sclk_q;
  assign lead_edge   = sclk_chg && (sclk_s2 != cpol);
  assign trail_edge  = sclk_chg && (sclk_s2 == cpol);
  assign sample_edge = cpha ? trail_edge : lead_edge;
  assign shift_edge  = cpha ? lead_edge : trail_edge;
  assign word_done   = bit_cnt == CNT_W'(WIDTH);
  assign load_word   = tx_valid ? tx_data : IDLE_FILL[WIDTH-1:0];

  // Control FSM with shifters; a shift edge while bit_cnt is zero is the one
  // that follows a word load, where the MSB is already on miso, so it is skipped.
  always_ff @(posedge clk_in or posedge async_rst) begin
    if (async_rst) begin
      state       <= IDLE;
      tx_sh       <= '0;
      rx_sh       <= '0;
      bit_cnt     <= '0;
      miso        <= 1'b1;
      miso_oe     <= 1'b0;
      tx_ready    <= 1'b0;
      tx_underrun <= 1'b0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      rx_abort    <= 1'b0;
    end else begin
      tx_ready    <= 1'b0;
      tx_underrun <= 1'b0;
      rx_valid    <= 1'b0;
      rx_abort    <= 1'b0;
      case (state)
        IDLE: begin
          if (!cs_s2) begin
            state       <= ACTIVE;
            tx_sh       <= load_word;
            miso        <= load_word[WIDTH-1];
            tx_ready    <= tx_valid;
            tx_underrun <= !tx_valid;
            bit_cnt     <= '0;
            miso_oe     <= 1'b1;
          end
        end
        ACTIVE: begin
          if (word_done) begin
            rx_data  <= rx_sh;
            rx_valid <= 1'b1;
            bit_cnt  <= '0;
          end
          if (cs_s2) begin
            state   <= IDLE;
            miso_oe <= 1'b0;
            miso    <= 1'b1;
            if (bit_cnt != '0 && !word_done) begin
              rx_abort <= 1'b1;
            end
          end else if (word_done) begin
            tx_sh       <= load_word;
            miso        <= load_word[WIDTH-1];
            tx_ready    <= tx_valid;
            tx_underrun <= !tx_valid;
          end else begin
            if (sample_edge) begin
              rx_sh   <= {rx_sh[WIDTH-2:0], mosi_s2};
              bit_cnt <= bit_cnt + CNT_W'(1);
            end
            if (shift_edge && bit_cnt != '0) begin
              tx_sh <= {tx_sh[WIDTH-2:0], tx_sh[WIDTH-1]};
              miso  <= tx_sh[WIDTH-2];
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_target_shifter.sv
// Directed bench for spi_target_shifter: an SPI controller model drives sclk at
// 1/8 of clk_in, a tx word source answers tx_ready, and pulses are counted.
module tb_spi_target_shifter;

  logic       clk_in = 1'b0;
  logic       async_rst = 1'b1;
  logic       cpol = 1'b0;
  logic       cpha = 1'b0;
  logic       sclk = 1'b0;
  logic       cs_n = 1'b1;
  logic       mosi = 1'b0;
  logic       miso;
  logic       miso_oe;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx_underrun;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_abort;

  int n_total = 0;
  int n_bad = 0;

  logic [7:0] tx_words [16];
  int tx_wr = 0;
  int tx_rd = 0;

  int n_rxv = 0, n_txr = 0, n_und = 0, n_abt = 0;
  int s_rxv, s_txr, s_und, s_abt;
  logic [7:0] rx_hist [2];
  time t_rxv = 0;
  time t_last = 0;
  int oe_err = 0;
  logic [15:0] mi;

  assign tx_valid = tx_rd < tx_wr;
  assign tx_data  = tx_words[tx_rd[3:0]];

  spi_target_shifter #(.WIDTH(8), .IDLE_FILL(16'h00FF)) dut (
    .clk_in(clk_in), .async_rst(async_rst), .cpol(cpol), .cpha(cpha),
    .sclk(sclk), .cs_n(cs_n), .mosi(mosi), .miso(miso), .miso_oe(miso_oe),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .tx_underrun(tx_underrun), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_abort(rx_abort)
  );

  always #5 clk_in = ~clk_in;

  // Pulse counters and tx source pop, sampled away from the active edge
  always @(negedge clk_in) begin
    if (rx_valid) begin
      n_rxv++;
      rx_hist[1] = rx_hist[0];
      rx_hist[0] = rx_data;
      t_rxv = $time;
    end
    if (tx_ready) begin
      n_txr++;
      tx_rd++;
    end
    if (tx_underrun) n_und++;
    if (rx_abort) n_abt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [7:0] w);
    tx_words[tx_wr[3:0]] = w;
    tx_wr++;
  endtask

  task automatic snap();
    s_rxv = n_rxv;
    s_txr = n_txr;
    s_und = n_und;
    s_abt = n_abt;
    oe_err = 0;
  endtask

  // Controller model: half period 40ns, captures miso at each sample edge
  task automatic xfer(input int nbits, input logic [15:0] mo, input bit end_cs,
                      output logic [15:0] got);
    got = '0;
    cs_n = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      if (!cpha) begin
        mosi = mo[nbits-1-i];
        #40;
        sclk = ~cpol;
        got = {got[14:0], miso};
        if (!miso_oe) oe_err++;
        t_last = $time;
        #40;
        sclk = cpol;
      end else begin
        #40;
        sclk = ~cpol;
        mosi = mo[nbits-1-i];
        #40;
        sclk = cpol;
        got = {got[14:0], miso};
        if (!miso_oe) oe_err++;
        t_last = $time;
      end
    end
    if (end_cs) begin
      #40;
      cs_n = 1'b1;
      #200;
    end
  endtask

  initial begin
    rx_hist[0] = '0;
    rx_hist[1] = '0;

    // Reset values
    #23;
    check("rst_miso", 32'(miso), 32'h1);
    check("rst_oe", 32'(miso_oe), 32'h0);
    check("rst_rx_data", 32'(rx_data), 32'h0);
    check("rst_pulses", 32'({tx_ready, tx_underrun, rx_valid, rx_abort}), 32'h0);
    #17;
    async_rst = 1'b0;
    #80;

    // Mode 0 single word
    snap();
    push(8'h3C);
    xfer(8, 16'h00A5, 1'b1, mi);
    check("m0_miso", 32'(mi[7:0]), 32'h3C);
    check("m0_rx_data", 32'(rx_data), 32'hA5);
    check("m0_rxv", 32'(n_rxv - s_rxv), 32'd1);
    check("m0_txr", 32'(n_txr - s_txr), 32'd1);
    check("m0_und", 32'(n_und - s_und), 32'd1);
    check("m0_abt", 32'(n_abt - s_abt), 32'd0);
    check("m0_latency", 32'(t_rxv - t_last), 32'd40);
    check("m0_oe_active", 32'(oe_err), 32'd0);
    check("m0_oe_idle", 32'({miso_oe, miso}), 32'h1);

    // Mode 3 single word
    cpol = 1'b1;
    cpha = 1'b1;
    sclk = 1'b1;
    #80;
    snap();
    push(8'hC3);
    xfer(8, 16'h005A, 1'b1, mi);
    check("m3_miso", 32'(mi[7:0]), 32'hC3);
    check("m3_rx_data", 32'(rx_data), 32'h5A);
    check("m3_rxv", 32'(n_rxv - s_rxv), 32'd1);
    check("m3_txr", 32'(n_txr - s_txr), 32'd1);
    check("m3_latency", 32'(t_rxv - t_last), 32'd40);
    check("m3_oe_active", 32'(oe_err), 32'd0);

    // Back-to-back words in one cs_n low, mode 0
    cpol = 1'b0;
    cpha = 1'b0;
    sclk = 1'b0;
    #80;
    snap();
    push(8'h01);
    push(8'h80);
    xfer(16, 16'h0180, 1'b1, mi);
    check("b2b_miso", 32'(mi), 32'h0180);
    check("b2b_rxv", 32'(n_rxv - s_rxv), 32'd2);
    check("b2b_first", 32'(rx_hist[1]), 32'h01);
    check("b2b_second", 32'(rx_hist[0]), 32'h80);
    check("b2b_txr", 32'(n_txr - s_txr), 32'd2);
    check("b2b_und", 32'(n_und - s_und), 32'd1);

    // Partial word then release: abort
    snap();
    xfer(5, 16'h0015, 1'b1, mi);
    check("abt_pulse", 32'(n_abt - s_abt), 32'd1);
    check("abt_rxv", 32'(n_rxv - s_rxv), 32'd0);
    check("abt_rx_data", 32'(rx_data), 32'h80);
    check("abt_oe", 32'(miso_oe), 32'h0);

    // No tx word offered: underrun and idle fill
    snap();
    xfer(8, 16'h0012, 1'b1, mi);
    check("und_miso", 32'(mi[7:0]), 32'hFF);
    check("und_pulses", 32'(n_und - s_und), 32'd2);
    check("und_txr", 32'(n_txr - s_txr), 32'd0);
    check("und_rx_data", 32'(rx_data), 32'h12);

    // Reset mid-word, then a clean word
    snap();
    xfer(3, 16'h0005, 1'b0, mi);
    #3;
    async_rst = 1'b1;
    #1;
    check("mid_rst_miso", 32'({miso_oe, miso}), 32'h1);
    check("mid_rst_rx_data", 32'(rx_data), 32'h0);
    #6;
    cs_n = 1'b1;
    #40;
    async_rst = 1'b0;
    #80;
    check("mid_rst_abt", 32'(n_abt - s_abt), 32'd0);
    check("mid_rst_rxv", 32'(n_rxv - s_rxv), 32'd0);
    push(8'h96);
    xfer(8, 16'h0077, 1'b1, mi);
    check("post_rst_rx", 32'(rx_data), 32'h77);
    check("post_rst_miso", 32'(mi[7:0]), 32'h96);
    check("post_rst_rxv", 32'(n_rxv - s_rxv), 32'd1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
